// File: rtl/channel_initial_select.sv
// Channel-side initial-selection sequencer driving the B interface.
// Host: start/device_addr/command in; busy/done/result/status out.
// B side: bus/tag "out" signals driven here, bus/tag "in" consumed.
module channel_initial_select #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] device_addr,
  input  logic [7:0] command,
  output logic       busy,
  output logic       done,
  output logic [2:0] result,
  output logic [7:0] status,
  output logic [7:0] b_bus_out,
  output logic       b_bus_out_parity,
  output logic       b_operational_out,
  output logic       b_hold_out,
  output logic       b_select_out,
  output logic       b_address_out,
  output logic       b_command_out,
  output logic       b_service_out,
  output logic       b_suppress_out,
  input  logic [7:0] b_bus_in,
  input  logic       b_bus_in_parity,
  input  logic       b_operational_in,
  input  logic       b_select_in,
  input  logic       b_address_in,
  input  logic       b_status_in,
  input  logic       b_service_in
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_SELECT, S_CHECK, S_CMD_SET,
    S_CMD_WAIT, S_STATUS, S_SVC, S_DESEL, S_DONE
  } state_t;

  localparam logic [2:0] R_OK     = 3'd0;
  localparam logic [2:0] R_NODEV  = 3'd1;
  localparam logic [2:0] R_MISM   = 3'd2;
  localparam logic [2:0] R_PARITY = 3'd3;
  localparam logic [2:0] R_TMO    = 3'd4;
  localparam logic [2:0] R_IFBUSY = 3'd5;

  localparam logic [CNT_WIDTH-1:0] SET_LAST =
    CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [7:0]           addr_q;
  logic [7:0]           cmd_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 bus_in_ok;
  logic                 tmo;
  logic                 set_end;
  logic                 to_desel;
  logic                 unused_in;

  assign unused_in      = b_service_in;
  assign b_suppress_out = 1'b0;
  assign bus_in_ok      = ^{b_bus_in, b_bus_in_parity};
  assign tmo            = (cnt == TMO_LAST);
  assign set_end        = (cnt == SET_LAST);

  // Any path into DESELECT: aborts plus the normal end of service.
  // An awaited event always beats a timeout on the same cycle.
  always_comb begin
    to_desel = 1'b0;
    case (state)
      S_SELECT:
        to_desel = !(b_operational_in && b_address_in)
                   && (b_select_in || tmo);
      S_CHECK:
        to_desel = !bus_in_ok || (b_bus_in != addr_q);
      S_CMD_WAIT:
        to_desel = b_address_in && tmo;
      S_STATUS:
        to_desel = b_status_in ? !bus_in_ok : tmo;
      S_SVC:
        to_desel = !b_status_in || tmo;
      default:
        to_desel = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      addr_q            <= '0;
      cmd_q             <= '0;
      cnt               <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      result            <= R_OK;
      status            <= '0;
      b_bus_out         <= '0;
      b_bus_out_parity  <= 1'b0;
      b_operational_out <= 1'b0;
      b_hold_out        <= 1'b0;
      b_select_out      <= 1'b0;
      b_address_out     <= 1'b0;
      b_command_out     <= 1'b0;
      b_service_out     <= 1'b0;
    end else begin
      b_operational_out <= 1'b1;
      done              <= 1'b0;
      cnt               <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (b_operational_in || b_select_in) begin
              result <= R_IFBUSY;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              addr_q           <= device_addr;
              cmd_q            <= command;
              result           <= R_OK;
              status           <= '0;
              busy             <= 1'b1;
              b_bus_out        <= device_addr;
              b_bus_out_parity <= ~^device_addr;
              b_address_out    <= 1'b1;
              cnt              <= '0;
              state            <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (set_end) begin
            b_select_out <= 1'b1;
            b_hold_out   <= 1'b1;
            cnt          <= '0;
            state        <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (b_operational_in && b_address_in) begin
            cnt   <= '0;
            state <= S_CHECK;
          end else if (b_select_in) begin
            result <= R_NODEV;
          end else if (tmo) begin
            result <= R_TMO;
          end
        end
        S_CHECK: begin
          if (!bus_in_ok) begin
            result <= R_PARITY;
          end else if (b_bus_in != addr_q) begin
            result <= R_MISM;
          end else begin
            b_address_out    <= 1'b0;
            b_bus_out        <= cmd_q;
            b_bus_out_parity <= ~^cmd_q;
            cnt              <= '0;
            state            <= S_CMD_SET;
          end
        end
        S_CMD_SET: begin
          if (set_end) begin
            b_command_out <= 1'b1;
            cnt           <= '0;
            state         <= S_CMD_WAIT;
          end
        end
        S_CMD_WAIT: begin
          if (!b_address_in) begin
            b_command_out <= 1'b0;
            cnt           <= '0;
            state         <= S_STATUS;
          end else if (tmo) begin
            result <= R_TMO;
          end
        end
        S_STATUS: begin
          if (b_status_in) begin
            if (bus_in_ok) begin
              status        <= b_bus_in;
              b_service_out <= 1'b1;
              cnt           <= '0;
              state         <= S_SVC;
            end else begin
              result <= R_PARITY;
            end
          end else if (tmo) begin
            result <= R_TMO;
          end
        end
        S_SVC: begin
          if (b_status_in && tmo) result <= R_TMO;
        end
        S_DESEL: begin
          if (!b_operational_in) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (tmo) begin
            result <= R_TMO;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Entering DESELECT drops every tag and clears the bus.
      if (to_desel) begin
        b_select_out     <= 1'b0;
        b_hold_out       <= 1'b0;
        b_address_out    <= 1'b0;
        b_command_out    <= 1'b0;
        b_service_out    <= 1'b0;
        b_bus_out        <= '0;
        b_bus_out_parity <= 1'b1;
        cnt              <= '0;
        state            <= S_DESEL;
      end
    end
  end

endmodule

// File: tb/tb_channel_initial_select.sv
// Directed bench for channel_initial_select.
// Drives a scripted device on the B side; checks against fixed values.
module tb_channel_initial_select;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] device_addr;
  logic [7:0] command;
  logic       busy;
  logic       done;
  logic [2:0] result;
  logic [7:0] status;
  logic [7:0] b_bus_out;
  logic       b_bus_out_parity;
  logic       b_operational_out;
  logic       b_hold_out;
  logic       b_select_out;
  logic       b_address_out;
  logic       b_command_out;
  logic       b_service_out;
  logic       b_suppress_out;
  logic [7:0] b_bus_in;
  logic       b_bus_in_parity;
  logic       b_operational_in;
  logic       b_select_in;
  logic       b_address_in;
  logic       b_status_in;
  logic       b_service_in;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cmd_cnt = 0;
  int svc_cnt = 0;
  int tag_cnt = 0;

  localparam int W_ADDR = 0;
  localparam int W_SEL  = 1;
  localparam int W_CMD  = 2;
  localparam int W_SVC  = 3;
  localparam int W_DONE = 4;

  channel_initial_select #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(32),
    .CNT_WIDTH     (16)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .device_addr      (device_addr),
    .command          (command),
    .busy             (busy),
    .done             (done),
    .result           (result),
    .status           (status),
    .b_bus_out        (b_bus_out),
    .b_bus_out_parity (b_bus_out_parity),
    .b_operational_out(b_operational_out),
    .b_hold_out       (b_hold_out),
    .b_select_out     (b_select_out),
    .b_address_out    (b_address_out),
    .b_command_out    (b_command_out),
    .b_service_out    (b_service_out),
    .b_suppress_out   (b_suppress_out),
    .b_bus_in         (b_bus_in),
    .b_bus_in_parity  (b_bus_in_parity),
    .b_operational_in (b_operational_in),
    .b_select_in      (b_select_in),
    .b_address_in     (b_address_in),
    .b_status_in      (b_status_in),
    .b_service_in     (b_service_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (b_command_out) cmd_cnt++;
    if (b_service_out) svc_cnt++;
    if (b_select_out | b_hold_out | b_address_out |
        b_command_out | b_service_out) tag_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      W_ADDR:  return b_address_out;
      W_SEL:   return b_select_out;
      W_CMD:   return b_command_out;
      W_SVC:   return b_service_out;
      default: return done;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val,
                          input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      if (sig(sel) === val) hit = 1'b1;
    end
    chk(tag, {31'd0, hit}, 32'd1);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic dev_idle();
    b_bus_in         = 8'h00;
    b_bus_in_parity  = 1'b0;
    b_operational_in = 1'b0;
    b_select_in      = 1'b0;
    b_address_in     = 1'b0;
    b_status_in      = 1'b0;
    b_service_in     = 1'b0;
  endtask

  task automatic go(input logic [7:0] a, input logic [7:0] c);
    device_addr = a;
    command     = c;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] all_out();
    return {3'd0, busy, done, result, status, b_bus_out,
            b_bus_out_parity, b_operational_out, b_hold_out,
            b_select_out, b_address_out, b_command_out,
            b_service_out, b_suppress_out};
  endfunction

  int c0;
  int n;

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    device_addr = 8'h00;
    command     = 8'h00;
    dev_idle();
    cyc(3);
    chk("reset_outs", all_out(), 32'd0);
    #2 reset_n = 1'b1;
    cyc(1);
    chk("op_out_after_reset", {31'd0, b_operational_out}, 32'd1);
    chk("suppress_low", {31'd0, b_suppress_out}, 32'd0);

    // Happy path: 0x8E / 0x02, status 0x0C.
    c0 = svc_cnt;
    go(8'h8E, 8'h02);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_sig(W_ADDR, 1'b1, "hp_addr_out");
    chk("hp_bus_addr", {24'd0, b_bus_out}, 32'h8E);
    chk("hp_par_addr", {31'd0, b_bus_out_parity}, 32'd1);
    wait_sig(W_SEL, 1'b1, "hp_select");
    chk("hp_hold", {31'd0, b_hold_out}, 32'd1);
    b_operational_in = 1'b1;
    b_address_in     = 1'b1;
    b_bus_in         = 8'h8E;
    b_bus_in_parity  = 1'b1;
    wait_sig(W_CMD, 1'b1, "hp_cmd_out");
    chk("hp_bus_cmd", {24'd0, b_bus_out}, 32'h02);
    chk("hp_par_cmd", {31'd0, b_bus_out_parity}, 32'd0);
    chk("hp_addr_dropped", {31'd0, b_address_out}, 32'd0);
    b_address_in = 1'b0;
    wait_sig(W_CMD, 1'b0, "hp_cmd_drop");
    b_bus_in        = 8'h0C;
    b_bus_in_parity = 1'b1;
    b_status_in     = 1'b1;
    wait_sig(W_SVC, 1'b1, "hp_svc_out");
    b_status_in = 1'b0;
    wait_sig(W_SVC, 1'b0, "hp_svc_drop");
    chk("hp_desel", {31'd0, b_select_out}, 32'd0);
    dev_idle();
    wait_sig(W_DONE, 1'b1, "hp_done");
    chk("hp_result", {29'd0, result}, 32'd0);
    chk("hp_status", {24'd0, status}, 32'h0C);
    chk("hp_svc_seen", {31'd0, svc_cnt != c0}, 32'd1);
    cyc(1);
    chk("hp_busy_low", {31'd0, busy}, 32'd0);
    chk("hp_done_pulse", {31'd0, done}, 32'd0);
    chk("hp_tags_low",
        {27'd0, b_select_out, b_hold_out, b_address_out,
         b_command_out, b_service_out}, 32'd0);

    // No device: select_in comes back 10 cycles into SELECT.
    c0 = cmd_cnt;
    go(8'h8E, 8'h02);
    wait_sig(W_SEL, 1'b1, "nd_select");
    cyc(9);
    b_select_in = 1'b1;
    wait_sig(W_SEL, 1'b0, "nd_sel_drop");
    chk("nd_hold_drop", {31'd0, b_hold_out}, 32'd0);
    b_select_in = 1'b0;
    wait_sig(W_DONE, 1'b1, "nd_done");
    chk("nd_result", {29'd0, result}, 32'd1);
    chk("nd_no_cmd", cmd_cnt - c0, 32'd0);
    cyc(1);

    // Address mismatch: device answers 0x8F (valid parity).
    c0 = cmd_cnt;
    go(8'h8E, 8'h02);
    wait_sig(W_SEL, 1'b1, "mm_select");
    b_operational_in = 1'b1;
    b_address_in     = 1'b1;
    b_bus_in         = 8'h8F;
    b_bus_in_parity  = 1'b0;
    wait_sig(W_ADDR, 1'b0, "mm_addr_drop");
    dev_idle();
    wait_sig(W_DONE, 1'b1, "mm_done");
    chk("mm_result", {29'd0, result}, 32'd2);
    chk("mm_no_cmd", cmd_cnt - c0, 32'd0);
    cyc(1);

    // Bad parity on the status byte.
    c0 = svc_cnt;
    go(8'h8E, 8'h02);
    wait_sig(W_SEL, 1'b1, "pe_select");
    b_operational_in = 1'b1;
    b_address_in     = 1'b1;
    b_bus_in         = 8'h8E;
    b_bus_in_parity  = 1'b1;
    wait_sig(W_CMD, 1'b1, "pe_cmd_out");
    b_address_in = 1'b0;
    wait_sig(W_CMD, 1'b0, "pe_cmd_drop");
    b_bus_in        = 8'h0C;
    b_bus_in_parity = 1'b0;
    b_status_in     = 1'b1;
    wait_sig(W_SEL, 1'b0, "pe_desel");
    dev_idle();
    wait_sig(W_DONE, 1'b1, "pe_done");
    chk("pe_result", {29'd0, result}, 32'd3);
    chk("pe_no_svc", svc_cnt - c0, 32'd0);
    cyc(1);

    // Timeout: no response in SELECT, TIMEOUT_CYCLES=32.
    go(8'h8E, 8'h02);
    wait_sig(W_SEL, 1'b1, "to_select");
    n = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      n++;
    end
    chk("to_latency", n, 32'd33);
    chk("to_result", {29'd0, result}, 32'd4);
    cyc(1);

    // Interface busy: operational_in high at start.
    c0 = tag_cnt;
    b_operational_in = 1'b1;
    go(8'h8E, 8'h02);
    chk("ib_done", {31'd0, done}, 32'd1);
    chk("ib_result", {29'd0, result}, 32'd5);
    chk("ib_busy", {31'd0, busy}, 32'd0);
    cyc(2);
    chk("ib_no_tags", tag_cnt - c0, 32'd0);
    dev_idle();

    // Async reset in the middle of CMD.
    go(8'h8E, 8'h02);
    wait_sig(W_SEL, 1'b1, "rs_select");
    b_operational_in = 1'b1;
    b_address_in     = 1'b1;
    b_bus_in         = 8'h8E;
    b_bus_in_parity  = 1'b1;
    wait_sig(W_CMD, 1'b1, "rs_cmd_out");
    c0 = done_cnt;
    #2 reset_n = 1'b0;
    #1 chk("rs_outs_zero", all_out(), 32'd0);
    dev_idle();
    cyc(3);
    chk("rs_no_done", done_cnt - c0, 32'd0);
    #2 reset_n = 1'b1;
    cyc(1);
    chk("rs_op_out", {31'd0, b_operational_out}, 32'd1);
    chk("rs_idle", {31'd0, busy}, 32'd0);
    cyc(2);
    chk("rs_still_no_done", done_cnt - c0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/channel_initial_select.md
Name: channel_initial_select

Overview:
- Channel-side sequencer that drives the "B" interface of the parallel-channel frontend.
- Performs the bus-and-tag initial selection sequence for one device: address-out, select/hold, address-in check, command-out, status-in capture, service-out acknowledge, deselect.
- A host-side start/done handshake carries the device address and command, and returns the status byte plus a result code.
- Sits directly upstream of the frontend; all B-side "out" signals originate here, and all B-side "in" signals are consumed here.

Parameters:
- SETTLE_CYCLES, 4, clocks that bus_out must be stable before a tag is raised (skew allowance).
- TIMEOUT_CYCLES, 65535, maximum clocks spent in any wait state before aborting.
- CNT_WIDTH, 16, width of the shared settle/timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- device_addr  in  8  device address; latched on start
- command  in  8  command byte; latched on start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the sequence ends
- result  out  3  0=OK 1=NO_DEVICE 2=ADDR_MISMATCH 3=PARITY 4=TIMEOUT 5=INTERFACE_BUSY; valid with done, held until the next start
- status  out  8  captured status byte; valid when result=OK, held until the next start
- b_bus_out  out  8  bus out to frontend
- b_bus_out_parity  out  1  odd parity of b_bus_out
- b_operational_out, b_hold_out, b_select_out, b_address_out, b_command_out, b_service_out, b_suppress_out  out  1 each  tags to frontend
- b_bus_in  in  8  bus in from frontend (already synchronised)
- b_bus_in_parity  in  1  bus in parity
- b_operational_in, b_select_in, b_address_in, b_status_in, b_service_in  in  1 each  tags from frontend

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state IDLE; result=0; status=0.
  - b_operational_out goes to 1 on the first clock after release and stays 1 while out of reset.
  - b_suppress_out is always 0.
- Parity: b_bus_out_parity = ~^b_bus_out, registered together with b_bus_out. The bus_in check uses the same rule: ^{b_bus_in, b_bus_in_parity} must equal 1.
- Counter: cleared on every state entry. In SETTLE states it counts up to SETTLE_CYCLES-1. In WAIT states, reaching TIMEOUT_CYCLES-1 gives result=TIMEOUT and a transition to DESELECT.
- IDLE -> ADDR on start.
  - If b_operational_in or b_select_in is high at start: do not enter ADDR; pulse done next cycle with result=INTERFACE_BUSY.
- ADDR (settle):
  - b_bus_out=addr latch, b_address_out=1.
  - After SETTLE_CYCLES -> SELECT.
- SELECT (wait):
  - b_select_out=1, b_hold_out=1.
  - b_operational_in & b_address_in -> CHECK.
  - b_select_in -> result=NO_DEVICE, go to DESELECT (select propagated through all devices with no response).
- CHECK (1 cycle):
  - Parity bad -> PARITY, go to DESELECT.
  - Else b_bus_in != addr latch -> ADDR_MISMATCH, go to DESELECT.
  - Else drop b_address_out and go to CMD.
- CMD (settle then wait):
  - b_bus_out=cmd latch.
  - After SETTLE_CYCLES, raise b_command_out.
  - Wait for b_address_in low, then drop b_command_out -> STATUS.
- STATUS (wait):
  - On b_status_in: check parity (bad -> PARITY, DESELECT).
  - Otherwise capture status <= b_bus_in, raise b_service_out -> SVC.
- SVC (wait):
  - When b_status_in falls, drop b_service_out -> DESELECT.
- DESELECT (wait):
  - Drop b_select_out, b_hold_out, b_address_out, b_command_out, b_service_out; b_bus_out=0.
  - Wait for b_operational_in low (subject to timeout) -> DONE.
  - Timeout here forces result=TIMEOUT, overriding any earlier result.
- DONE: done=1 for one cycle, busy=0 next cycle -> IDLE.
- Error paths: every abort drops all tags before DONE; no tag is ever left asserted in IDLE.
- Simultaneous events:
  - b_select_in and b_address_in asserted together in SELECT: address_in wins.
  - start while busy: ignored.
  - Timeout and the awaited event on the same cycle: the event wins.
- Reset mid-sequence: all tags drop immediately (async); no done pulse.

Test Plan:
- Happy path, addr=0x8E, cmd=0x02; device model returns address_in with 0x8E/parity ok, then status 0x0C -> address_out high with 0x8E, command_out with 0x02, service_out follows status_in; done with result=0, status=0x0C; all tags low after done.
- No device: select_in returned 10 cycles into SELECT -> select/hold drop, done with result=1, command_out never asserted.
- Address mismatch: device returns 0x8F for request 0x8E -> result=2, address_out drops, command_out never raised.
- Bad parity on status byte 0x0C (parity bit inverted) -> result=3, service_out never raised.
- Timeout with TIMEOUT_CYCLES=32: device never responds in SELECT -> done exactly 32 cycles after SELECT entry plus the deselect/done cycles, result=4.
- Busy interface plus async reset: operational_in high at start -> result=5 with no tags raised. Separately, assert reset_n low during CMD -> all outputs 0 within the same cycle, FSM in IDLE, no done pulse.
